// File: rtl/pkt_rx_param.sv
`default_nettype none
// ============================================================================
// Module   : pkt_rx_param
// Brief    : Parametrised header/payload/checksum word-stream packet receiver
// Revision : 1.0 - initial release
// ============================================================================
module pkt_rx_param #(
    parameter int            DW      = 8,
    parameter int            NBYTES  = 2,
    parameter logic [DW-1:0] HEAD    = 8'hCA,
    parameter int            CHK_EN  = 1,
    parameter int            TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cs,
    input  logic                 in_valid,
    input  logic [DW-1:0]        d_in,
    output logic                 out_valid,
    output logic [DW*NBYTES-1:0] d_out,
    output logic                 err,
    output logic [1:0]           err_code,
    output logic                 busy
);

    localparam int SW = DW * NBYTES;
    localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [CW-1:0] C_LAST  = CW'(NBYTES - 1);
    localparam logic [TW-1:0] C_TLAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    localparam logic [1:0] C_ERR_HDR = 2'b01;
    localparam logic [1:0] C_ERR_CHK = 2'b10;
    localparam logic [1:0] C_ERR_TMO = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        CHECK   = 2'd2
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [SW-1:0] r_shift;
    logic [DW-1:0] r_chk;
    logic [TW-1:0] r_idle;
    logic [SW-1:0] w_shift_next;
    logic          w_expire;

    // Single-word packets have nothing to shift through.
    generate
        if (NBYTES == 1) begin : g_shift_one
            assign w_shift_next = d_in;
        end else begin : g_shift_many
            assign w_shift_next = {r_shift[SW-DW-1:0], d_in};
        end
    endgenerate

    assign w_expire = (TIMEOUT > 0) && (r_state != IDLE) && !in_valid
                      && (r_idle == C_TLAST);

    assign busy = (r_state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_shift   <= '0;
            r_chk     <= '0;
            r_idle    <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
            err_code  <= 2'b00;
            d_out     <= '0;
        end else begin
            out_valid <= 1'b0;
            err       <= 1'b0;
            if (cs) begin
                r_state <= IDLE;
                r_cnt   <= '0;
                r_chk   <= '0;
                r_idle  <= '0;
            end else if (w_expire) begin
                r_state  <= IDLE;
                r_cnt    <= '0;
                r_chk    <= '0;
                r_idle   <= '0;
                err      <= 1'b1;
                err_code <= C_ERR_TMO;
            end else begin
                // Idle counter only runs mid-packet and only if enabled.
                if (in_valid || r_state == IDLE || TIMEOUT == 0) begin
                    r_idle <= '0;
                end else begin
                    r_idle <= r_idle + 1'b1;
                end

                if (in_valid) begin
                    case (r_state)
                        IDLE: begin
                            if (d_in == HEAD) begin
                                r_state <= PAYLOAD;
                                r_cnt   <= '0;
                                r_chk   <= '0;
                            end else begin
                                err      <= 1'b1;
                                err_code <= C_ERR_HDR;
                            end
                        end
                        PAYLOAD: begin
                            r_shift <= w_shift_next;
                            r_chk   <= r_chk ^ d_in;
                            r_cnt   <= r_cnt + 1'b1;
                            if (r_cnt == C_LAST) begin
                                r_cnt <= '0;
                                if (CHK_EN != 0) begin
                                    r_state <= CHECK;
                                end else begin
                                    r_state   <= IDLE;
                                    d_out     <= w_shift_next;
                                    out_valid <= 1'b1;
                                end
                            end
                        end
                        CHECK: begin
                            r_state <= IDLE;
                            r_chk   <= '0;
                            if (d_in == r_chk) begin
                                d_out     <= r_shift;
                                out_valid <= 1'b1;
                            end else begin
                                err      <= 1'b1;
                                err_code <= C_ERR_CHK;
                            end
                        end
                        default: r_state <= IDLE;
                    endcase
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pkt_rx_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_pkt_rx_param
// Brief    : Self-checking directed bench for pkt_rx_param (default params)
// Revision : 1.0 - initial release
// ============================================================================
module tb_pkt_rx_param;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cs = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  d_in = 8'h00;
    logic        out_valid;
    logic [15:0] d_out;
    logic        err;
    logic [1:0]  err_code;
    logic        busy;

    int n_checks = 0;
    int n_fails  = 0;

    pkt_rx_param dut (
        .clk       (clk),
        .rst       (rst),
        .cs        (cs),
        .in_valid  (in_valid),
        .d_in      (d_in),
        .out_valid (out_valid),
        .d_out     (d_out),
        .err       (err),
        .err_code  (err_code),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        ov;
        logic        e;
        logic [1:0]  code;
        logic [15:0] dout;
        logic        bsy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic v, input logic [7:0] d, input logic ov,
                       input logic e, input logic [1:0] code,
                       input logic [15:0] dout, input logic bsy);
        vec_t t;
        t.v = v; t.d = d; t.ov = ov; t.e = e; t.code = code; t.dout = dout; t.bsy = bsy;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic ov, input logic e,
                             input logic [1:0] code, input logic [15:0] dout,
                             input logic bsy);
        check({tag, ".out_valid"}, {15'd0, out_valid}, {15'd0, ov});
        check({tag, ".err"},       {15'd0, err},       {15'd0, e});
        check({tag, ".err_code"},  {14'd0, err_code},  {14'd0, code});
        check({tag, ".d_out"},     d_out,              dout);
        check({tag, ".busy"},      {15'd0, busy},      {15'd0, bsy});
    endtask

    // Apply inputs, clock once, then sample away from the edge.
    task automatic drive(input logic v, input logic [7:0] d, input logic c, input logic r);
        in_valid = v; d_in = d; cs = c; rst = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Good packet, header error then good packet, checksum error,
        // back-to-back zero-gap packets, idle gap in IDLE.
        add(1, 8'hCA, 0, 0, 2'd0, 16'h0000, 1);
        add(1, 8'h12, 0, 0, 2'd0, 16'h0000, 1);
        add(1, 8'h34, 0, 0, 2'd0, 16'h0000, 1);
        add(1, 8'h26, 1, 0, 2'd0, 16'h1234, 0);
        add(1, 8'h55, 0, 1, 2'd1, 16'h1234, 0);
        add(1, 8'hCA, 0, 0, 2'd1, 16'h1234, 1);
        add(1, 8'hAB, 0, 0, 2'd1, 16'h1234, 1);
        add(1, 8'hCD, 0, 0, 2'd1, 16'h1234, 1);
        add(1, 8'h66, 1, 0, 2'd1, 16'hABCD, 0);
        add(0, 8'h00, 0, 0, 2'd1, 16'hABCD, 0);
        add(1, 8'hCA, 0, 0, 2'd1, 16'hABCD, 1);
        add(1, 8'h12, 0, 0, 2'd1, 16'hABCD, 1);
        add(1, 8'h34, 0, 0, 2'd1, 16'hABCD, 1);
        add(1, 8'h00, 0, 1, 2'd2, 16'hABCD, 0);
        add(1, 8'hCA, 0, 0, 2'd2, 16'hABCD, 1);
        add(1, 8'h01, 0, 0, 2'd2, 16'hABCD, 1);
        add(1, 8'h02, 0, 0, 2'd2, 16'hABCD, 1);
        add(1, 8'h03, 1, 0, 2'd2, 16'h0102, 0);
        add(1, 8'hCA, 0, 0, 2'd2, 16'h0102, 1);
        add(1, 8'h04, 0, 0, 2'd2, 16'h0102, 1);
        add(1, 8'h05, 0, 0, 2'd2, 16'h0102, 1);
        add(1, 8'h01, 1, 0, 2'd2, 16'h0405, 0);
        add(0, 8'h00, 0, 0, 2'd2, 16'h0405, 0);

        drive(0, 8'h00, 0, 1);
        drive(0, 8'h00, 0, 1);
        check_all("reset", 0, 0, 2'd0, 16'h0000, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].v, vecs[i].d, 0, 0);
            check_all($sformatf("vec%0d", i), vecs[i].ov, vecs[i].e,
                      vecs[i].code, vecs[i].dout, vecs[i].bsy);
        end

        // Timeout: 16 idle cycles mid-packet abort.
        drive(1, 8'hCA, 0, 0);
        drive(1, 8'h12, 0, 0);
        for (int i = 1; i <= 15; i++) begin
            drive(0, 8'h00, 0, 0);
            check_all($sformatf("tmo_wait%0d", i), 0, 0, 2'd2, 16'h0405, 1);
        end
        drive(0, 8'h00, 0, 0);
        check_all("tmo_fire", 0, 1, 2'd3, 16'h0405, 0);
        drive(0, 8'h00, 0, 0);
        check_all("tmo_after", 0, 0, 2'd3, 16'h0405, 0);

        // 15 idle cycles is still within budget.
        drive(1, 8'hCA, 0, 0);
        drive(1, 8'h12, 0, 0);
        for (int i = 1; i <= 15; i++) drive(0, 8'h00, 0, 0);
        check_all("tmo15_busy", 0, 0, 2'd3, 16'h0405, 1);
        drive(1, 8'h34, 0, 0);
        drive(1, 8'h26, 0, 0);
        check_all("tmo15_good", 1, 0, 2'd3, 16'h1234, 0);

        // cs abort mid-packet: no pulses, outputs held.
        drive(1, 8'hCA, 0, 0);
        drive(1, 8'hAB, 0, 0);
        drive(0, 8'h00, 1, 0);
        check_all("cs_abort", 0, 0, 2'd3, 16'h1234, 0);
        drive(0, 8'h00, 0, 0);
        check_all("cs_next", 0, 0, 2'd3, 16'h1234, 0);

        // rst mid-packet, then a good packet.
        drive(1, 8'hCA, 0, 0);
        drive(1, 8'h55, 0, 0);
        drive(0, 8'h00, 0, 1);
        check_all("rst_mid", 0, 0, 2'd0, 16'h0000, 0);
        drive(1, 8'hCA, 0, 0);
        drive(1, 8'h12, 0, 0);
        drive(1, 8'h34, 0, 0);
        drive(1, 8'h26, 0, 0);
        check_all("rst_good", 1, 0, 2'd0, 16'h1234, 0);
        drive(0, 8'h00, 0, 0);
        check_all("rst_good_end", 0, 0, 2'd0, 16'h1234, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
